des_feistel_mix: RTL and testbench

//  Downstream stage of the eight registered DES S-box lookups (s1..s8, 1-cycle latency, no stall).

---
 rtl/des_pkg.sv | 32 +++
 rtl/des_result_fifo.sv | 51 +++++
 rtl/des_feistel_mix.sv | 101 ++++++++++
 tb/tb_des_feistel_mix.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES definitions for the round datapath: half-block type, result record,
// permutation tables and the P permutation helper.
package des_pkg;

  typedef logic [31:0] des_half_t;

  typedef struct packed {
    logic [3:0] round;
    des_half_t  l;
    des_half_t  r;
  } mix_entry_t;

  localparam int MIX_ENTRY_W = $bits(mix_entry_t);

  // Entries are DES positions minus one (source bit index counted from the MSB),
  // which keeps every entry within 5 bits.
  localparam logic [4:0] P_TABLE [32] = '{
    5'd15, 5'd6,  5'd19, 5'd20, 5'd28, 5'd11, 5'd27, 5'd16,
    5'd0,  5'd14, 5'd22, 5'd25, 5'd4,  5'd17, 5'd30, 5'd9,
    5'd1,  5'd7,  5'd23, 5'd13, 5'd31, 5'd26, 5'd2,  5'd8,
    5'd18, 5'd12, 5'd29, 5'd5,  5'd21, 5'd10, 5'd3,  5'd24
  };

  function automatic des_half_t des_perm_p(input des_half_t x);
    des_half_t y;
    for (int i = 0; i < 32; i++) begin
      y[31-i] = x[31 - int'(P_TABLE[i])];
    end
    return y;
  endfunction

endpackage

// File: rtl/des_result_fifo.sv
// Round-result buffer: synchronous FIFO with occupancy count and a zeroed head
// while empty.
module des_result_fifo
  import des_pkg::*;
#(
  parameter int WIDTH = MIX_ENTRY_W,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_valid,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  assign o_valid = (r_count != '0);
  assign w_pop   = i_pop & o_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end

  // NOTE: storage is not reset; the head is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/des_feistel_mix.sv
// DES round back end: aligns L/R with the registered S-box result, applies P,
// XOR and the Feistel swap, and buffers results behind a credit-based in_ready.
module des_feistel_mix
  import des_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LAST_ROUND = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_l,
  input  logic [31:0] in_r,
  input  logic [3:0]  in_round,
  input  logic [31:0] sbox_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_l,
  output logic [31:0] out_r,
  output logic [3:0]  out_round
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;

  logic          r_v1;
  des_half_t     r_l;
  des_half_t     r_r;
  logic [3:0]    r_round;
  logic          r_in_ready;

  logic          w_acc;
  logic          w_pop;
  logic          w_fifo_valid;
  logic [CW-1:0] w_count;
  logic [OW-1:0] w_occ_next;
  des_half_t     w_f;
  mix_entry_t    w_entry;
  mix_entry_t    w_head;

  assign w_acc = in_valid & r_in_ready;
  assign w_pop = w_fifo_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset) r_v1 <= 1'b0;
    else        r_v1 <= w_acc;
  end

  // Align data is only consumed while r_v1 is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_l     <= in_l;
      r_r     <= in_r;
      r_round <= in_round;
    end
  end

  // NOTE: every field is assigned on every path, so no latch is inferred.
  always_comb begin
    w_f           = des_perm_p(sbox_dout);
    w_entry.round = r_round;
    if (r_round == 4'(LAST_ROUND)) begin
      w_entry.l = r_l ^ w_f;
      w_entry.r = r_r;
    end else begin
      w_entry.l = r_r;
      w_entry.r = r_l ^ w_f;
    end
  end

  // Occupancy after this edge counts the entry in the mix stage, so the
  // unstallable S-box stage always has a FIFO slot waiting for it.
  assign w_occ_next = OW'(w_count) + OW'(r_v1) + OW'(w_acc) - OW'(w_pop);

  always_ff @(posedge clk) begin
    if (!reset) r_in_ready <= 1'b0;
    else        r_in_ready <= (w_occ_next < OW'(FIFO_DEPTH));
  end

  des_result_fifo #(
    .WIDTH (MIX_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_v1),
    .i_wdata (w_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_valid (w_fifo_valid),
    .o_count (w_count)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = w_fifo_valid;
  assign out_l     = w_head.l;
  assign out_r     = w_head.r;
  assign out_round = w_head.round;

endmodule

// File: tb/tb_des_feistel_mix.sv
// Bench for des_feistel_mix: constant vector table, single-bit P walk, stall/drain,
// a full 16-round DES run from a reference model, and a mid-operation reset.
module tb_des_feistel_mix;

  localparam int DEPTH = 4;

  localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int S_T [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic [3:0]  rnd;
    logic [31:0] sbox;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_l;
  logic [31:0] in_r;
  logic [3:0]  in_round;
  logic [31:0] sbox_dout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_l;
  logic [31:0] out_r;
  logic [3:0]  out_round;

  logic [31:0] pend_sbox;
  logic [67:0] sb_q [$];
  logic [67:0] last_pop;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [31:0] des_l    [16];
  logic [31:0] des_r    [16];
  logic [31:0] des_sbox [16];
  logic [67:0] des_exp  [16];
  vec_t        vecs     [8];

  des_feistel_mix #(.FIFO_DEPTH(DEPTH), .LAST_ROUND(15)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_l(in_l), .in_r(in_r), .in_round(in_round), .sbox_dout(sbox_dout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_l(out_l), .out_r(out_r), .out_round(out_round)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered S-box stage: real data one cycle after an accept, noise otherwise.
  always @(posedge clk) sbox_dout <= (in_valid && in_ready) ? pend_sbox : $urandom;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      last_pop = {out_round, out_l, out_r};
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h, want no output", last_pop);
      end else begin
        check("scoreboard", last_pop, sb_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    for (int j = 0; j < 32; j++) y[31-j] = x[32-P_T[j]];
    return y;
  endfunction

  function automatic logic [67:0] mix_model(input logic [31:0] l, r, input logic [3:0] rnd,
                                            input logic [31:0] sbox);
    logic [31:0] f;
    f = perm_p(sbox);
    if (rnd == 4'd15) return {rnd, l ^ f, r};
    return {rnd, r, l ^ f};
  endfunction

  function automatic logic [31:0] sbox_layer(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  six;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      y[31-4*b -: 4] = 4'(S_T[b][int'({six[5], six[0]})*16 + int'(six[4:1])]);
    end
    return y;
  endfunction

  task automatic build_des_vectors(input logic [63:0] key, input logic [63:0] msg);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [55:0] sub;
    logic [47:0] k48, e48;
    logic [63:0] ip;
    logic [31:0] l, r, s, f;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 64; i++) ip[63-i] = msg[64-IP_T[i]];
    l = ip[63:32];
    r = ip[31:0];
    for (int rd = 0; rd < 16; rd++) begin
      for (int k = 0; k < SHIFT_T[rd]; k++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      sub = {c, d};
      for (int i = 0; i < 48; i++) k48[47-i] = sub[56-PC2_T[i]];
      for (int i = 0; i < 48; i++) e48[47-i] = r[32-E_T[i]];
      s = sbox_layer(e48 ^ k48);
      des_l[rd]    = l;
      des_r[rd]    = r;
      des_sbox[rd] = s;
      f = perm_p(s);
      if (rd < 15) {l, r} = {r, l ^ f};
      else         l = l ^ f;
      des_exp[rd] = {4'(rd), l, r};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] l, r, input logic [3:0] rnd, input logic [31:0] sbox,
                      input logic [67:0] exp);
    int budget = 100;
    in_valid  = 1'b1;
    in_l      = l;
    in_r      = r;
    in_round  = rnd;
    pend_sbox = sbox;
    while (!in_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!in_ready) begin
      check("send_in_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    sb_q.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget = 50;
    while (sb_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check("drain_complete", 68'(sb_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int jpos;
    logic [31:0] x;
    longint t0;

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_l = '0; in_r = '0; in_round = '0; pend_sbox = '0;
    build_des_vectors(64'h1334_5779_9BBC_DFF1, 64'h0123_4567_89AB_CDEF);
    vecs[0] = '{32'h0000_0000, 32'h1234_5678, 4'd0,  32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF};
    vecs[1] = '{32'h0000_0000, 32'h0000_0000, 4'd3,  32'h8000_0000, 32'h0000_0000, 32'h0080_0000};
    vecs[2] = '{32'hFFFF_FFFF, 32'hA5A5_A5A5, 4'd15, 32'h0000_0000, 32'hFFFF_FFFF, 32'hA5A5_A5A5};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 4'd15, 32'h8000_0000, 32'h0080_0000, 32'h0000_0000};
    vecs[4] = '{32'hFFFF_FFFF, 32'hDEAD_BEEF, 4'd7,  32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[5] = '{32'h0000_0000, 32'h0000_0001, 4'd14, 32'h0000_0001, 32'h0000_0001, 32'h0000_0800};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 4'd0,  32'h0000_8000, 32'h0000_0000, 32'h0100_0000};
    vecs[7] = '{32'hCC00_CCFF, 32'hF0AA_F0AA, 4'd0,  32'h5C82_B597, 32'hF0AA_F0AA, 32'hEF4A_6544};

    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", {out_round, out_l, out_r}, 0);
    reset = 1'b1;
    tick();
    check("rel_in_ready", in_ready, 1);

    // Vector table; the first entry also pins the two-cycle latency.
    out_ready = 1'b1;
    send(vecs[0].l, vecs[0].r, vecs[0].rnd, vecs[0].sbox, {vecs[0].rnd, vecs[0].exp_l, vecs[0].exp_r});
    check("latency_cycle1_valid", out_valid, 0);
    tick();
    check("latency_cycle2_valid", out_valid, 1);
    for (int i = 1; i < 8; i++)
      send(vecs[i].l, vecs[i].r, vecs[i].rnd, vecs[i].sbox, {vecs[i].rnd, vecs[i].exp_l, vecs[i].exp_r});
    wait_drain();

    // Single-bit walk: expected position found by inverse lookup in P.
    for (int b = 0; b < 32; b++) begin
      x = 32'h1 << b;
      jpos = -1;
      for (int j = 0; j < 32; j++) if (P_T[j] == 32 - b) jpos = j;
      send(32'h0, 32'h0, 4'd3, x, {4'd3, 32'h0, 32'h1 << (31 - jpos)});
    end
    wait_drain();

    // Stall: in_valid held with out_ready low, then release.
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_l = $urandom; in_r = $urandom; in_round = 4'(c); pend_sbox = $urandom;
      if (in_ready) begin
        acc++;
        sb_q.push_back(mix_model(in_l, in_r, in_round, pend_sbox));
      end
      tick();
    end
    in_valid = 1'b0;
    check("stall_accepts", 68'(acc), 4);
    check("stall_in_ready", in_ready, 0);
    if (sb_q.size() > 0) check("stall_head_hold", {out_round, out_l, out_r}, sb_q[0]);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_out_valid", out_valid, 1);
      tick();
    end
    check("drain_empty", out_valid, 0);
    check("drain_scoreboard", 68'(sb_q.size()), 0);
    check("drain_in_ready", in_ready, 1);

    // Full DES encryption, one round per cycle.
    t0 = $time;
    for (int rd = 0; rd < 16; rd++)
      send(des_l[rd], des_r[rd], 4'(rd), des_sbox[rd], des_exp[rd]);
    check("des_throughput_cycles", 68'(($time - t0) / 10), 16);
    wait_drain();
    check("des_preoutput", last_pop, {4'd15, 64'h0A4C_D995_4342_3234});

    // Reset with three entries buffered and one in the mix stage.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_l = $urandom; in_r = $urandom; x = $urandom;
      send(in_l, in_r, 4'(k + 4), x, mix_model(in_l, in_r, 4'(k + 4), x));
    end
    check("pre_rst_in_ready", in_ready, 0);
    reset = 1'b0;
    tick();
    sb_q.delete();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_data", {out_round, out_l, out_r}, 0);
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);
    tick(); tick(); tick();
    check("post_rst_no_output", out_valid, 0);
    send(vecs[7].l, vecs[7].r, vecs[7].rnd, vecs[7].sbox, {vecs[7].rnd, vecs[7].exp_l, vecs[7].exp_r});
    wait_drain();
    check("post_rst_result", last_pop, {vecs[7].rnd, vecs[7].exp_l, vecs[7].exp_r});

    tick(); tick();
    check("final_scoreboard_empty", 68'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
